pc_fetch_unit: RTL and testbench

//  Program-counter register and instruction-fetch sequencer for the core.
//  - Holds PC and drives it to the PC/immediate adder, which returns PC_4 and PC_Imm.
//  - Selects the next PC, fetches from instruction memory over a req/ready handshake,
//    and presents the instruction to decode.
//  - Commits the next PC when the core signals Step.

---
 rtl/pc_fetch_unit_if.sv | 33 +++
 rtl/pc_fetch_unit.sv | 121 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus bundle: adder results, next-PC select, commit controls,
// instruction-memory handshake and the PC/instruction outputs to decode.
//   master : the fetch unit (drives pc, imem request, instr, status)
//   slave  : core / adder / instruction memory side
interface pc_fetch_unit_if;
  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] pc_4;
  logic [XLEN-1:0] pc_imm;
  logic [XLEN-1:0] alu_out;
  logic [1:0]      pc_sel;
  logic            step;
  logic            stall;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] instr;
  logic            instr_valid;
  logic            misalign_trap;
  logic [XLEN-1:0] instr_count;

  modport master (
    input  pc_4, pc_imm, alu_out, pc_sel, step, stall, imem_ready, imem_rdata,
    output imem_req, imem_addr, pc, instr, instr_valid, misalign_trap, instr_count
  );

  modport slave (
    output pc_4, pc_imm, alu_out, pc_sel, step, stall, imem_ready, imem_rdata,
    input  imem_req, imem_addr, pc, instr, instr_valid, misalign_trap, instr_count
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program-counter register and instruction-fetch sequencer.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : pc_fetch_unit_if.master
//            inputs  pc_4, pc_imm, alu_out, pc_sel, step, stall, imem_ready, imem_rdata
//            outputs imem_req, imem_addr (= pc), pc, instr, instr_valid,
//                    misalign_trap (one-cycle pulse), instr_count
// Sequence: BOOT (one cycle) -> FETCH (request until imem_ready) -> EXEC
// (wait for an unstalled step, commit next PC) -> FETCH ...
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input logic              clk,
  input logic              rst_n,
  pc_fetch_unit_if.master  bus
);
  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            valid_q, valid_d;
  logic            trap_q, trap_d;
  logic [XLEN-1:0] count_q, count_d;
  logic            req_q, req_d;

  logic [XLEN-1:0] target_c;
  logic            misaligned_c;

  // Next-PC candidate; JALR target has bit 0 cleared before the alignment check.
  always_comb begin
    target_c     = bus.pc_4;
    misaligned_c = 1'b0;
    unique case (bus.pc_sel)
      2'b00:   target_c = bus.pc_4;
      2'b01:   target_c = bus.pc_imm;
      2'b10:   target_c = bus.alu_out & ~XLEN'(1);
      default: target_c = TRAP_VECTOR;
    endcase
    misaligned_c = (bus.pc_sel != 2'b11) && (target_c[1:0] != 2'b00);
  end

  // Sequencer next-state and next-register values.
  // imem_req is registered from the next state so it is high exactly while in FETCH.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    trap_d  = 1'b0;
    count_d = count_q;
    req_d   = 1'b0;

    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
        req_d   = 1'b1;
      end
      FETCH: begin
        req_d = 1'b1;
        if (bus.imem_ready) begin
          instr_d = bus.imem_rdata;
          valid_d = 1'b1;
          state_d = EXEC;
          req_d   = 1'b0;
        end
      end
      EXEC: begin
        if (bus.step && !bus.stall) begin
          pc_d    = misaligned_c ? TRAP_VECTOR : target_c;
          trap_d  = misaligned_c;
          valid_d = 1'b0;
          count_d = count_q + XLEN'(1);
          state_d = FETCH;
          req_d   = 1'b1;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      trap_q  <= 1'b0;
      count_q <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      trap_q  <= trap_d;
      count_q <= count_d;
      req_q   <= req_d;
    end
  end

  assign bus.imem_req      = req_q;
  assign bus.imem_addr     = pc_q;
  assign bus.pc            = pc_q;
  assign bus.instr         = instr_q;
  assign bus.instr_valid   = valid_q;
  assign bus.misalign_trap = trap_q;
  assign bus.instr_count   = count_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: inputs are driven and outputs sampled on
// the falling edge; the PC/immediate adder is modelled as pc + 4.
module tb_pc_fetch_unit;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   exp_cnt;

  pc_fetch_unit_if bus ();

  pc_fetch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.pc_4 = bus.pc + 32'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.pc_imm = '0; bus.alu_out = '0; bus.pc_sel = 2'b00;
    bus.step = 1'b0; bus.stall = 1'b0;
    bus.imem_ready = 1'b1; bus.imem_rdata = 32'h0000_1111;
    exp_cnt = 0;
    @(negedge clk); @(negedge clk);
    checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL rst_pc act=%h exp=%h", bus.pc, 32'h0); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req act=%b exp=0", bus.imem_req); end
    checks++; if (bus.instr !== 32'h13) begin errors++; $display("FAIL rst_instr act=%h exp=%h", bus.instr, 32'h13); end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid act=%b exp=0", bus.instr_valid); end
    checks++; if (bus.misalign_trap !== 1'b0) begin errors++; $display("FAIL rst_trap act=%b exp=0", bus.misalign_trap); end
    checks++; if (bus.instr_count !== 32'h0) begin errors++; $display("FAIL rst_count act=%h exp=0", bus.instr_count); end
    rst_n = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL boot_req act=%b exp=0", bus.imem_req); end
    tick();
    // ready was high during BOOT and must have been ignored
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL fetch_req act=%b exp=1", bus.imem_req); end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL boot_ready_ignored act=%b exp=0", bus.instr_valid); end
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL fetch_addr act=%h exp=0", bus.imem_addr); end
    tick();
    checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL first_valid act=%b exp=1", bus.instr_valid); end
    checks++; if (bus.instr !== 32'h0000_1111) begin errors++; $display("FAIL first_instr act=%h exp=%h", bus.instr, 32'h0000_1111); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL exec_req act=%b exp=0", bus.imem_req); end
  endtask

  task automatic test_sequential();
    bus.pc_sel = 2'b00; bus.step = 1'b1; bus.imem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.imem_rdata = 32'h0000_2000 + 32'(i);
      tick();
      exp_cnt++;
      checks++; if (bus.pc !== 32'(4 * (i + 1))) begin errors++; $display("FAIL seq_pc[%0d] act=%h exp=%h", i, bus.pc, 32'(4 * (i + 1))); end
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL seq_valid_drop[%0d] act=%b exp=0", i, bus.instr_valid); end
      checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL seq_req[%0d] act=%b exp=1", i, bus.imem_req); end
      tick();
      checks++; if (bus.instr !== 32'h0000_2000 + 32'(i)) begin errors++; $display("FAIL seq_instr[%0d] act=%h exp=%h", i, bus.instr, 32'h0000_2000 + 32'(i)); end
    end
    checks++; if (bus.instr_count !== 32'd4) begin errors++; $display("FAIL seq_count act=%0d exp=4", bus.instr_count); end
  endtask

  task automatic test_branch_jalr();
    bus.pc_sel = 2'b01; bus.pc_imm = 32'h40; bus.step = 1'b1;
    tick(); exp_cnt++;
    checks++; if (bus.pc !== 32'h40) begin errors++; $display("FAIL branch_pc act=%h exp=%h", bus.pc, 32'h40); end
    checks++; if (bus.misalign_trap !== 1'b0) begin errors++; $display("FAIL branch_trap act=%b exp=0", bus.misalign_trap); end
    tick();
    bus.pc_sel = 2'b10; bus.alu_out = 32'h81;
    tick(); exp_cnt++;
    checks++; if (bus.pc !== 32'h80) begin errors++; $display("FAIL jalr_pc act=%h exp=%h", bus.pc, 32'h80); end
    checks++; if (bus.misalign_trap !== 1'b0) begin errors++; $display("FAIL jalr_trap act=%b exp=0", bus.misalign_trap); end
    tick();
  endtask

  task automatic test_misalign();
    bus.pc_sel = 2'b01; bus.pc_imm = 32'h42; bus.step = 1'b1;
    tick(); exp_cnt++;
    checks++; if (bus.pc !== 32'h100) begin errors++; $display("FAIL mis_pc act=%h exp=%h", bus.pc, 32'h100); end
    checks++; if (bus.misalign_trap !== 1'b1) begin errors++; $display("FAIL mis_trap_on act=%b exp=1", bus.misalign_trap); end
    bus.imem_ready = 1'b0;
    tick();
    checks++; if (bus.misalign_trap !== 1'b0) begin errors++; $display("FAIL mis_trap_pulse act=%b exp=0", bus.misalign_trap); end
    bus.imem_ready = 1'b1;
    tick();
    bus.pc_sel = 2'b10; bus.alu_out = 32'h83;
    tick(); exp_cnt++;
    checks++; if (bus.pc !== 32'h100) begin errors++; $display("FAIL mis_jalr_pc act=%h exp=%h", bus.pc, 32'h100); end
    checks++; if (bus.misalign_trap !== 1'b1) begin errors++; $display("FAIL mis_jalr_trap act=%b exp=1", bus.misalign_trap); end
    tick();
    bus.pc_sel = 2'b11;
    tick(); exp_cnt++;
    checks++; if (bus.pc !== 32'h100) begin errors++; $display("FAIL trapsel_pc act=%h exp=%h", bus.pc, 32'h100); end
    checks++; if (bus.misalign_trap !== 1'b0) begin errors++; $display("FAIL trapsel_trap act=%b exp=0", bus.misalign_trap); end
  endtask

  task automatic test_handshake_stall();
    bus.imem_ready = 1'b0; bus.imem_rdata = 32'hDEAD_BEEF; bus.step = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin errors++; $display("FAIL hold_req[%0d] act=%b/%h exp=1/%h", i, bus.imem_req, bus.imem_addr, 32'h100); end
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL hold_valid[%0d] act=%b exp=0", i, bus.instr_valid); end
    end
    bus.imem_ready = 1'b1; bus.imem_rdata = 32'hABCD_0001;
    tick();
    checks++; if (bus.instr !== 32'hABCD_0001 || bus.instr_valid !== 1'b1) begin errors++; $display("FAIL hs_instr act=%h/%b exp=%h/1", bus.instr, bus.instr_valid, 32'hABCD_0001); end
    bus.stall = 1'b1; bus.step = 1'b1; bus.pc_sel = 2'b00; bus.imem_rdata = 32'h5555_5555;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus.pc !== 32'h100 || bus.instr !== 32'hABCD_0001) begin errors++; $display("FAIL stall_hold[%0d] act=%h/%h exp=%h/%h", i, bus.pc, bus.instr, 32'h100, 32'hABCD_0001); end
      checks++; if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_ctl[%0d] act=%b/%b exp=1/0", i, bus.instr_valid, bus.imem_req); end
    end
    bus.stall = 1'b0;
    tick(); exp_cnt++;
    checks++; if (bus.pc !== 32'h104) begin errors++; $display("FAIL stall_release_pc act=%h exp=%h", bus.pc, 32'h104); end
    checks++; if (bus.instr_count !== 32'(exp_cnt)) begin errors++; $display("FAIL stall_count act=%0d exp=%0d", bus.instr_count, exp_cnt); end
  endtask

  task automatic test_wrap();
    bus.step = 1'b0; bus.imem_ready = 1'b1;
    tick();
    bus.step = 1'b1; bus.pc_sel = 2'b10; bus.alu_out = 32'hFFFF_FFFC;
    tick(); exp_cnt++;
    checks++; if (bus.pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_jalr_pc act=%h exp=%h", bus.pc, 32'hFFFF_FFFC); end
    tick();
    bus.pc_sel = 2'b00;
    tick(); exp_cnt++;
    checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL wrap_pc act=%h exp=0", bus.pc); end
    checks++; if (bus.misalign_trap !== 1'b0) begin errors++; $display("FAIL wrap_trap act=%b exp=0", bus.misalign_trap); end
    checks++; if (bus.instr_count !== 32'(exp_cnt)) begin errors++; $display("FAIL wrap_count act=%0d exp=%0d", bus.instr_count, exp_cnt); end
  endtask

  task automatic test_reset_mid_fetch();
    bus.step = 1'b0; bus.imem_ready = 1'b0;
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL pend_req act=%b exp=1", bus.imem_req); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL midrst_req act=%b exp=0", bus.imem_req); end
    checks++; if (bus.pc !== 32'h0 || bus.instr_count !== 32'h0) begin errors++; $display("FAIL midrst_pc_cnt act=%h/%h exp=0/0", bus.pc, bus.instr_count); end
    checks++; if (bus.instr !== 32'h13 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL midrst_instr act=%h/%b exp=%h/0", bus.instr, bus.instr_valid, 32'h13); end
    bus.imem_ready = 1'b1; bus.imem_rdata = 32'h7777_0000;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (bus.imem_req !== 1'b1 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reboot_fetch act=%b/%b exp=1/0", bus.imem_req, bus.instr_valid); end
    tick();
    checks++; if (bus.instr !== 32'h7777_0000 || bus.instr_valid !== 1'b1) begin errors++; $display("FAIL reboot_instr act=%h/%b exp=%h/1", bus.instr, bus.instr_valid, 32'h7777_0000); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sequential();
    test_branch_jalr();
    test_misalign();
    test_handshake_stall();
    test_wrap();
    test_reset_mid_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
